// File: rtl/dual_read_single_write_reg_file.sv
// Register file with one write port and two independently enabled read ports.
// Registered read data and valid bits; optional write-to-read forwarding and hardwired-zero entry 0.
module dual_read_single_write_reg_file #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              read_enable_a,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic              read_enable_b,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [WIDTH-1:0]  read_data_a,
    output logic              read_valid_a,
    output logic [WIDTH-1:0]  read_data_b,
    output logic              read_valid_b,
    output logic              addr_error
);

    localparam logic BYPASS_ON = (BYPASS != 0);
    localparam logic ZERO_ON   = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic             wr_in_range;
    logic             wr_commit;
    logic             rd_in_range_a;
    logic             rd_in_range_b;
    logic [WIDTH-1:0] arr_data_a;
    logic [WIDTH-1:0] arr_data_b;
    logic             arr_valid_a;
    logic             arr_valid_b;
    logic [WIDTH-1:0] nxt_data_a;
    logic [WIDTH-1:0] nxt_data_b;
    logic             nxt_valid_a;
    logic             nxt_valid_b;
    logic             nxt_error;

    // Address qualification; entry 0 is read-only when hardwired to zero
    always_comb begin
        wr_in_range   = (32'(write_addr) < DEPTH);
        rd_in_range_a = (32'(read_addr_a) < DEPTH);
        rd_in_range_b = (32'(read_addr_b) < DEPTH);
        wr_commit     = write_enable && wr_in_range && !(ZERO_ON && (write_addr == '0));
        nxt_error     = (write_enable && !wr_in_range)
                      || (read_enable_a && !rd_in_range_a)
                      || (read_enable_b && !rd_in_range_b);
    end

    // Array read muxes built as decoders so out-of-range addresses never index the array
    always_comb begin
        arr_data_a  = '0;
        arr_valid_a = 1'b0;
        arr_data_b  = '0;
        arr_valid_b = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (read_addr_a == ADDR_W'(i)) begin
                arr_data_a  = mem[i];
                arr_valid_a = valid[i];
            end
            if (read_addr_b == ADDR_W'(i)) begin
                arr_data_b  = mem[i];
                arr_valid_b = valid[i];
            end
        end
    end

    // Per-port result priority: range check, zero entry, forwarding, array
    always_comb begin
        nxt_data_a  = arr_data_a;
        nxt_valid_a = arr_valid_a;
        if (!rd_in_range_a) begin
            nxt_data_a  = '0;
            nxt_valid_a = 1'b0;
        end else if (ZERO_ON && (read_addr_a == '0)) begin
            nxt_data_a  = '0;
            nxt_valid_a = 1'b1;
        end else if (BYPASS_ON && wr_commit && (write_addr == read_addr_a)) begin
            nxt_data_a  = write_data;
            nxt_valid_a = 1'b1;
        end

        nxt_data_b  = arr_data_b;
        nxt_valid_b = arr_valid_b;
        if (!rd_in_range_b) begin
            nxt_data_b  = '0;
            nxt_valid_b = 1'b0;
        end else if (ZERO_ON && (read_addr_b == '0)) begin
            nxt_data_b  = '0;
            nxt_valid_b = 1'b1;
        end else if (BYPASS_ON && wr_commit && (write_addr == read_addr_b)) begin
            nxt_data_b  = write_data;
            nxt_valid_b = 1'b1;
        end
    end

    // Storage array and per-entry written flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_commit && (write_addr == ADDR_W'(i))) begin
                    mem[i]   <= write_data;
                    valid[i] <= 1'b1;
                end
            end
        end
    end

    // Output registers; each port holds its last result while not enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_a  <= '0;
            read_valid_a <= 1'b0;
            read_data_b  <= '0;
            read_valid_b <= 1'b0;
            addr_error   <= 1'b0;
        end else begin
            if (read_enable_a) begin
                read_data_a  <= nxt_data_a;
                read_valid_a <= nxt_valid_a;
            end
            if (read_enable_b) begin
                read_data_b  <= nxt_data_b;
                read_valid_b <= nxt_valid_b;
            end
            addr_error <= nxt_error;
        end
    end

endmodule

// File: doc/dual_read_single_write_reg_file.md
DUAL_READ_SINGLE_WRITE_REG_FILE -- requirements
Module: dual_read_single_write_reg_file

Parameters
REQ-001 SHALL provide WIDTH, default 16, data width in bits.
REQ-002 SHALL provide DEPTH, default 8, number of entries (2..256).
REQ-003 SHALL provide ADDR_W, default 3, address width; ceil(log2(DEPTH)) <= ADDR_W.
REQ-004 SHALL provide BYPASS, default 1, write-to-read forwarding: 1 = on, 0 = off.
REQ-005 SHALL provide ZERO_REG, default 0; 1 = entry 0 hardwired to zero.

Interface
REQ-006 SHALL have clk, input, 1, single clock; all state changes on the rising edge.
REQ-007 SHALL have reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have write_enable, input, 1, write request.
REQ-009 SHALL have write_addr, input, ADDR_W, write entry index.
REQ-010 SHALL have write_data, input, WIDTH, write value.
REQ-011 SHALL have read_enable_a and read_enable_b, input, 1 each, per-port read request.
REQ-012 SHALL have read_addr_a and read_addr_b, input, ADDR_W each, per-port read index.
REQ-013 SHALL have read_data_a and read_data_b, output, WIDTH each, registered read data.
REQ-014 SHALL have read_valid_a and read_valid_b, output, 1 each, registered: the addressed entry has been written since reset.
REQ-015 SHALL have addr_error, output, 1, registered one-cycle pulse on any enabled access with address >= DEPTH.

Function
REQ-016 SHALL, on a rising edge with write_enable=1 and write_addr<DEPTH, store write_data in mem[write_addr] and set valid[write_addr].
REQ-017 SHALL ignore writes to entry 0 when ZERO_REG=1: mem and valid unchanged, no error.
REQ-018 SHALL, on a rising edge with read_enable_x=1, load read_data_x/read_valid_x from mem/valid[read_addr_x]; read latency is exactly 1 cycle.
REQ-019 SHALL hold read_data_x and read_valid_x unchanged while read_enable_x=0.
REQ-020 SHALL, with BYPASS=1 and a same-edge write and read to the same legal address, return write_data and read_valid_x=1.
REQ-021 SHALL, with BYPASS=0 in the same case, return the pre-write contents and valid bit.
REQ-022 SHALL serve both ports independently; identical addresses on A and B return identical data.
REQ-023 SHALL, for an enabled read with address >= DEPTH, load read_data_x=0 and read_valid_x=0.
REQ-024 SHALL, for an enabled read of entry 0 with ZERO_REG=1, load read_data_x=0 and read_valid_x=1, with no bypass.
REQ-025 SHALL set addr_error=1 for one cycle after any edge with an enabled out-of-range read or write; otherwise 0.
REQ-026 SHALL drop an out-of-range write with no state change.

Reset
REQ-027 SHALL, while reset=0, asynchronously clear all mem entries and valid bits to 0.
REQ-028 SHALL, while reset=0, drive read_data_a/b=0, read_valid_a/b=0 and addr_error=0.
REQ-029 SHALL abort a write coinciding with reset assertion; the entry reads 0/invalid afterwards.
REQ-030 SHALL perform the first write or read on the first rising edge after reset deasserts.

Verification (WIDTH=16, DEPTH=8, ADDR_W=3 unless stated)
REQ-031 Reset, then read A addr 2 and B addr 5 -> next cycle read_data_a=0, read_data_b=0, both valid=0.
REQ-032 Write 25 to addr 2, next edge read A addr 2 with read_enable_b=0 -> read_data_a=25, read_valid_a=1; read_data_b holds its previous value.
REQ-033 Same-edge write 50 to addr 3 and read A+B addr 3, entry holding 25 -> BYPASS=1: both 50/valid=1; BYPASS=0: both 25.
REQ-034 DEPTH=6: write 75 to addr 7 -> addr_error pulses one cycle; reads of addr 0..5 are unchanged; read of addr 7 -> 0/invalid.
REQ-035 ZERO_REG=1: write 99 to addr 0, then read A addr 0 -> read_data_a=0, read_valid_a=1, addr_error=0.
REQ-036 Write 75 to addr 4, assert reset mid-cycle for 3 ns, then read addr 4 -> read_data=0, read_valid=0; outputs are 0 during reset.
